// File: rtl/uart_rx_os_if.sv
// Word handshake and error pulses between uart_rx_os (master) and its consumer (slave).
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 framing_error;
  logic                 overrun_error;
  logic                 parity_error;

  modport master (
    output rx_data, rx_valid, framing_error, overrun_error, parity_error,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, framing_error, overrun_error, parity_error,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with mid-bit 3-sample majority vote and a one-word output register.
// Optional even parity is enabled by defining UART_RX_PARITY_EN.
module uart_rx_os #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int DATA_BITS     = 8,
  parameter int OVERSAMPLE    = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_serial,
  uart_rx_os_if.master rx
);
  localparam int DIV_RAW = CLK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(DATA_BITS + 1);

  localparam logic [OS_W-1:0] SMP_LO  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] SMP_MID = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] SMP_HI  = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0] SMP_END = OS_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_nxt;
  logic                 sync_a, sync_b, line_prev;
  logic                 start_edge, go;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [OS_W-1:0]      os_cnt;
  logic [1:0]           smp;
  logic                 maj;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 sample_lo, sample_mid, decide, bit_end;
  logic                 frame_good, frame_bad;

  // Line idles high, so the synchronizer and edge history reset to 1 to avoid a false start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a    <= 1'b1;
      sync_b    <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
      sync_a    <= rx_serial;
      sync_b    <= sync_a;
      line_prev <= sync_b;
    end
  end

  assign start_edge = line_prev & ~sync_b;
  assign go         = (state == IDLE) && start_edge;
  assign tick       = (div_cnt == DIV_W'(DIV - 1));
  assign maj        = (smp[0] & smp[1]) | (smp[0] & sync_b) | (smp[1] & sync_b);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           div_cnt <= '0;
    else if (go || tick) div_cnt <= '0;
    else                 div_cnt <= div_cnt + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:  if (start_edge) state_nxt = START;
      START: begin
        if (decide && maj) state_nxt = IDLE;
        else if (bit_end)  state_nxt = DATA;
      end
      DATA: begin
        if (bit_end && bit_cnt == BIT_W'(DATA_BITS))
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_end) state_nxt = STOP;
`endif
      STOP:    if (decide) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sample_lo  = 1'b0;
    sample_mid = 1'b0;
    decide     = 1'b0;
    bit_end    = 1'b0;
    if (state != IDLE && tick) begin
      sample_lo  = (os_cnt == SMP_LO);
      sample_mid = (os_cnt == SMP_MID);
      decide     = (os_cnt == SMP_HI);
      bit_end    = (os_cnt == SMP_END);
    end
    frame_good = (state == STOP) && decide && maj;
    frame_bad  = (state == STOP) && decide && !maj;
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
`endif

  // NOTE: datapath registers are reset too, so rx_data and parity never expose X after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      os_cnt  <= '0;
      smp     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      if (go) begin
        os_cnt  <= '0;
        bit_cnt <= '0;
      end else if (state != IDLE && tick) begin
        os_cnt <= (os_cnt == SMP_END) ? '0 : os_cnt + OS_W'(1);
      end
      if (sample_lo)  smp[0] <= sync_b;
      if (sample_mid) smp[1] <= sync_b;
      if (state == DATA && decide) begin
        shreg   <= {maj, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && decide) par_bit <= maj;
`endif
    end
  end

  // Delivery happens at the stop decision edge, so rx_valid rises one cycle after the mid-sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx.rx_data       <= '0;
      rx.rx_valid      <= 1'b0;
      rx.framing_error <= 1'b0;
      rx.overrun_error <= 1'b0;
    end else begin
      rx.framing_error <= frame_bad;
      rx.overrun_error <= frame_good && rx.rx_valid && !rx.rx_ready;
      if (frame_good && (!rx.rx_valid || rx.rx_ready)) begin
        rx.rx_data  <= shreg;
        rx.rx_valid <= 1'b1;
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx.parity_error <= 1'b0;
    else       rx.parity_error <= frame_good && (^{shreg, par_bit});
  end
`else
  assign rx.parity_error = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed scoreboard bench for uart_rx_os at DIV=1 (16 clocks per bit, 8 data bits).
module tb_uart_rx_os;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_LEN = 11;
`else
  localparam int FRAME_LEN = 10;
`endif

  logic clk = 1'b0;
  logic reset;
  logic rx_serial;

  uart_rx_os_if #(.DATA_BITS(8)) bus ();

  uart_rx_os #(
    .CLK_FREQUENCY(16_000_000),
    .BAUD_RATE    (1_000_000),
    .DATA_BITS    (8),
    .OVERSAMPLE   (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_serial(rx_serial),
    .rx       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int load_cnt, valid_cyc, fe_cnt, oe_cnt, pe_cnt;
  logic prev_valid = 1'b0;
  logic prev_acc   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: a load is rx_valid seen after an idle register or after an accept.
  always @(negedge clk) begin
    if (bus.rx_valid && (!prev_valid || prev_acc)) begin
      load_cnt++;
      check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
    end
    if (bus.rx_valid)      valid_cyc++;
    if (bus.framing_error) fe_cnt++;
    if (bus.overrun_error) oe_cnt++;
    if (bus.parity_error)  pe_cnt++;
    prev_valid = bus.rx_valid;
    prev_acc   = bus.rx_valid && bus.rx_ready;
  end

  task automatic clear_counts();
    @(posedge clk);
    #1;
    load_cnt = 0; valid_cyc = 0; fe_cnt = 0; oe_cnt = 0; pe_cnt = 0;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #2 bus.rx_ready = r;
  endtask

  function automatic logic [11:0] make_frame(input logic [7:0] d, input logic stop,
                                             input logic bad_par);
    logic [11:0] fr;
    fr = '1;
    fr[0]   = 1'b0;
    fr[8:1] = d;
    fr[9]   = (^d) ^ bad_par;
    fr[FRAME_LEN-1] = stop;
    return fr;
  endfunction

  task automatic drive_bits(input logic [11:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_serial = fr[i];
      repeat (15) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic bad_par, input bit push);
    if (push) exp_q.push_back(d);
    drive_bits(make_frame(d, stop, bad_par), FRAME_LEN);
    rx_serial = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rx_serial = 1'b1;
    bus.rx_ready = 1'b1;
    idle(3);
    check("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("rst_data", {24'd0, bus.rx_data}, 32'd0);
    check("rst_fe", {31'd0, bus.framing_error}, 32'd0);
    check("rst_oe", {31'd0, bus.overrun_error}, 32'd0);
    check("rst_pe", {31'd0, bus.parity_error}, 32'd0);
    reset = 1'b0;
    idle(20);

    // Single frame, consumer always ready.
    clear_counts();
    send(8'hA5, 1'b1, 1'b0, 1'b1);
    idle(20);
    check("a5_loads", load_cnt, 32'd1);
    check("a5_valid_cycles", valid_cyc, 32'd1);
    check("a5_fe", fe_cnt, 32'd0);
    check("a5_oe", oe_cnt, 32'd0);
    check("a5_pe", pe_cnt, 32'd0);

    // Back-to-back frames while stalled: second word is dropped.
    set_ready(1'b0);
    clear_counts();
    send(8'h3C, 1'b1, 1'b0, 1'b1);
    send(8'h7E, 1'b1, 1'b0, 1'b0);
    idle(20);
    check("ovr_valid_held", {31'd0, bus.rx_valid}, 32'd1);
    check("ovr_data_held", {24'd0, bus.rx_data}, 32'h3C);
    check("ovr_oe", oe_cnt, 32'd1);
    check("ovr_loads", load_cnt, 32'd1);
    set_ready(1'b1);
    idle(2);
    check("ovr_valid_after_accept", {31'd0, bus.rx_valid}, 32'd0);
    check("ovr_sb_empty", exp_q.size(), 32'd0);

    // Stop bit forced low: frame discarded, then a good frame.
    clear_counts();
    send(8'h55, 1'b0, 1'b0, 1'b0);
    idle(16);
    check("fe_count", fe_cnt, 32'd1);
    check("fe_no_load", load_cnt, 32'd0);
    check("fe_valid", {31'd0, bus.rx_valid}, 32'd0);
    send(8'h12, 1'b1, 1'b0, 1'b1);
    idle(20);
    check("fe_next_loads", load_cnt, 32'd1);
    check("fe_next_fe", fe_cnt, 32'd1);

    // 4-cycle glitch on idle line is a false start.
    clear_counts();
    @(negedge clk);
    rx_serial = 1'b0;
    idle(4);
    rx_serial = 1'b1;
    idle(30);
    check("glitch_loads", load_cnt, 32'd0);
    check("glitch_fe", fe_cnt, 32'd0);
    send(8'hFF, 1'b1, 1'b0, 1'b1);
    idle(20);
    check("glitch_next_loads", load_cnt, 32'd1);

    // Reset mid data bit 4 while a word is held.
    set_ready(1'b0);
    clear_counts();
    send(8'h5A, 1'b1, 1'b0, 1'b1);
    idle(4);
    check("pre_rst_valid", {31'd0, bus.rx_valid}, 32'd1);
    drive_bits(make_frame(8'hC3, 1'b1, 1'b0), 5);
    @(negedge clk);
    rx_serial = 1'b0;
    idle(8);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("mid_rst_data", {24'd0, bus.rx_data}, 32'd0);
    check("mid_rst_errs", {29'd0, bus.framing_error, bus.overrun_error, bus.parity_error}, 32'd0);
    rx_serial = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(20);
    set_ready(1'b1);
    clear_counts();
    send(8'h81, 1'b1, 1'b0, 1'b1);
    idle(20);
    check("post_rst_loads", load_cnt, 32'd1);
    check("post_rst_errs", fe_cnt + oe_cnt + pe_cnt, 32'd0);

`ifdef UART_RX_PARITY_EN
    clear_counts();
    send(8'h07, 1'b1, 1'b1, 1'b1);
    idle(20);
    check("par_loads", load_cnt, 32'd1);
    check("par_valid_cycles", valid_cyc, 32'd1);
    check("par_pe", pe_cnt, 32'd1);
    check("par_fe", fe_cnt, 32'd0);
`endif

    check("final_sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
